stoch_wavg: RTL

- Weighted averager for NUM_POPS stochastic bitstreams; parametrised successor to the plain equal-weight averager.
- Output stream probability: y = sum(w_i * p_i) / W_TOT, where W_TOT is the sum of weights of mask-enabled channels.
- Adds runtime-loadable per-channel weights and a channel mask, input/output valid qualification, and a registered output.
- Sits between stochastic multipliers/adders and downstream stochastic consumers in the datapath.

---
 rtl/stoch_wavg.sv | 100 ++++++++++
 1 files changed

// File: rtl/stoch_wavg.sv
// Weighted averager of NUM_POPS stochastic bitstreams: y density = sum(w_i*p_i)/W_TOT.
// Optional macro STOCH_WAVG_PIPE_EN registers the weighted popcount (latency 2 instead of 1).
module stoch_wavg #(
  parameter int NUM_POPS     = 2,
  parameter int WEIGHT_WIDTH = 4,
  localparam int CW = $clog2(2*NUM_POPS*(2**WEIGHT_WIDTH-1)+1)
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             cfg_load,
  input  logic [NUM_POPS*WEIGHT_WIDTH-1:0] cfg_weights,
  input  logic [NUM_POPS-1:0]              cfg_mask,
  input  logic                             in_valid,
  input  logic [NUM_POPS-1:0]              a,
  output logic                             y,
  output logic                             out_valid,
  output logic [CW-1:0]                    residue
);

  // Valid semantics: there is no backpressure. A sample is taken on every edge where
  // in_valid=1 and cfg_load=0; out_valid marks the cycle its y bit is presented.

  logic [NUM_POPS*WEIGHT_WIDTH-1:0] w_q;
  logic [NUM_POPS-1:0]              mask_q;
  logic [CW-1:0]                    acc;
  logic [CW-1:0]                    wsum;
  logic [CW-1:0]                    wtot;
  logic [CW-1:0]                    acc_wsum;
  logic                             acc_valid;
  logic [CW-1:0]                    new_acc;

  always_comb begin
    wsum = '0;
    wtot = '0;
    for (int i = 0; i < NUM_POPS; i++) begin
      if (mask_q[i]) begin
        wtot = wtot + CW'(w_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        if (a[i]) wsum = wsum + CW'(w_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      end
    end
  end

`ifdef STOCH_WAVG_PIPE_EN
  logic          stg_valid;
  logic [CW-1:0] stg_wsum;

  // The stage is flushed on cfg_load, so a staged wsum always matches the live wtot.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stg_valid <= 1'b0;
      stg_wsum  <= '0;
    end else begin
      stg_valid <= in_valid & ~cfg_load;
      stg_wsum  <= wsum;
    end
  end

  assign acc_valid = stg_valid;
  assign acc_wsum  = stg_wsum;
`else
  assign acc_valid = in_valid;
  assign acc_wsum  = wsum;
`endif

  // acc < wtot and acc_wsum <= wtot, so new_acc < 2*wtot fits in CW bits.
  assign new_acc = acc + acc_wsum;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_POPS; i++) begin
        w_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= WEIGHT_WIDTH'(1);
      end
      mask_q    <= '1;
      acc       <= '0;
      y         <= 1'b0;
      out_valid <= 1'b0;
    end else if (cfg_load) begin
      w_q       <= cfg_weights;
      mask_q    <= cfg_mask;
      acc       <= '0;
      y         <= 1'b0;
      out_valid <= 1'b0;
    end else if (acc_valid && (wtot != '0)) begin
      out_valid <= 1'b1;
      if (new_acc >= wtot) begin
        y   <= 1'b1;
        acc <= new_acc - wtot;
      end else begin
        y   <= 1'b0;
        acc <= new_acc;
      end
    end else begin
      y         <= 1'b0;
      out_valid <= acc_valid;
    end
  end

  assign residue = acc;

endmodule
